fb_dump: RTL and testbench
==========================

# fb_dump

Parametrised framebuffer scan engine that sits between the pixel framebuffer RAM and any capture or display consumer. It walks the whole frame in raster order. In DUMP mode it reads every pixel and streams it out on a valid/ready port with position and frame flags, which is the hardware replacement for bench-side image dumping. In CLEAR mode it writes a constant colour to every pixel, which is the hardware replacement for bench-side zero-init.

## Interface
- H_RES, 640, pixels per line (≥2)
- V_RES, 480, lines per frame (≥1)
- CW, 6, pixel width in bits (RGB packed MSB-first, as in the framebuffer)
- AW, 19, framebuffer address width; must satisfy 2^AW ≥ H_RES*V_RES
- RD_LAT, 1, framebuffer read latency in cycles (1..3)
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- start  in  1  begin operation; sampled only in IDLE
- mode  in  1  0 = DUMP, 1 = CLEAR; sampled with start
- clear_val  in  CW  fill value; latched with start
- addr  out  AW  framebuffer address
- wen  out  1  framebuffer write enable (CLEAR only)
- dout  out  CW  framebuffer write data
- ren  out  1  framebuffer read enable (DUMP only)
- rdata  in  CW  framebuffer read data, valid RD_LAT cycles after ren
- pix_valid  out  1  stream data valid
- pix_ready  in  1  consumer accepts
- pix_data  out  CW  pixel value
- pix_x  out  10  column of pix_data
- pix_y  out  10  line of pix_data
- pix_sof, pix_eol, pix_eof  out  1  first pixel of frame / last of line / last of frame
- busy  out  1  high from the cycle after start until done
- done  out  1  one-cycle completion pulse

## Operation
- States: IDLE, CLEAR, DUMP, DRAIN, FIN.
- IDLE + start: go to CLEAR if mode=1, else DUMP. The x, y and address counters reset to 0. Start while busy is ignored.
- Addresses come from an incrementing counter (y*H_RES+x), never from a multiplier. x wraps at H_RES-1 and increments y. Nothing is issued after x=H_RES-1, y=V_RES-1.
- CLEAR: one write per cycle. wen=1, dout=latched clear_val, addr runs 0..H_RES*V_RES-1. After the last write, go to FIN.
- DUMP: a read is issued (ren=1) only when in-flight reads plus skid-FIFO occupancy is less than RD_LAT+1. rdata, tagged with x/y/flags from a RD_LAT-deep tag pipeline, enters a skid FIFO of depth RD_LAT+1. The FIFO head drives the pix_* outputs.
- Once the last read has issued, go to DRAIN. DRAIN moves to FIN when the pixel carrying pix_eof has been accepted.
- FIN: done=1 for one cycle, then IDLE.
- Flags: pix_sof at (0,0). pix_eol when x=H_RES-1. pix_eof at (H_RES-1, V_RES-1), with pix_eol also high.

## Timing
- Reset values: addr=0, wen=0, ren=0, dout=0, pix_valid=0, pix_data/x/y=0, all flags 0, busy=0, done=0. The skid FIFO is emptied and the state returns to IDLE.
- Reset asserted mid-operation aborts immediately. No pending pixel is presented after release.
- CLEAR: the first write occurs on the cycle after start. The last write is at cycle N=H_RES*V_RES. done pulses at cycle N+1.
- DUMP with pix_ready held high: the first pix_valid appears RD_LAT+1 cycles after start. After that, one pixel per cycle with no bubbles. done pulses the cycle after the pix_eof handshake.
- pix_data, pix_x, pix_y and all flags stay stable while pix_valid=1 and pix_ready=0. No pixel is dropped or duplicated under any backpressure pattern.
- A handshake occurs only when pix_valid and pix_ready are both 1 on the same edge.
- The skid FIFO never overflows. Reads resume on the same cycle a slot frees, so simultaneous push and pop is allowed.

## Configuration
- FB_DUMP_CLEAR_EN defined: CLEAR mode is implemented as above.
- FB_DUMP_CLEAR_EN undefined: the CLEAR state and the clear_val latch are removed, and wen/dout are tied to 0. start with mode=1 goes straight to FIN: done pulses on the cycle after start and no framebuffer access occurs. Ports are unchanged.

## Test plan
- Clear test (H_RES=4, V_RES=3, RD_LAT=1), macro defined. start, mode=1, clear_val=6'b110000 -> 12 writes on consecutive cycles, addr 0..11, dout=6'b110000. done pulses at cycle 13. wen is never high outside CLEAR.
- Dump test, same parameters, RAM preloaded with mem[k]=k, pix_ready=1 -> pix_data 0..11 in order.
  - x/y sequence: (0,0)…(3,2).
  - Flags: sof on pixel 0; eol on 3, 7 and 11; eof on 11.
  - Counts: first valid at cycle 2; done one cycle after pixel 11 is accepted.
- Dump test with RD_LAT=3 and pix_ready toggled in a pseudo-random pattern -> identical ordered 12-pixel sequence, outputs stable while stalled, in-flight plus FIFO never exceeds 4.
- Abort test: reset asserted after 5 accepted pixels of a dump -> all outputs at reset values. A new start then dumps from pixel 0. No done pulse is seen for the aborted frame.
- Clear-disabled build: macro undefined, start with mode=1 -> done at cycle 1, wen and ren stay 0. A subsequent start with mode=0 dumps normally.
- Busy test: start pulsed repeatedly during a dump -> no restart; exactly 12 pixels and exactly one done pulse.

Source files
------------

// File: rtl/fb_dump.sv
// rtl/fb_dump.sv - raster-order framebuffer dump / clear scan engine
// CLEAR mode is built only when FB_DUMP_CLEAR_EN is defined.
module fb_dump #(
  parameter int H_RES  = 640,
  parameter int V_RES  = 480,
  parameter int CW     = 6,
  parameter int AW     = 19,
  parameter int RD_LAT = 1
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          start_i,
  input  logic          mode_i,
  input  logic [CW-1:0] clear_val_i,
  output logic [AW-1:0] addr_o,
  output logic          wen_o,
  output logic [CW-1:0] dout_o,
  output logic          ren_o,
  input  logic [CW-1:0] rdata_i,
  output logic          pix_valid_o,
  input  logic          pix_ready_i,
  output logic [CW-1:0] pix_data_o,
  output logic [9:0]    pix_x_o,
  output logic [9:0]    pix_y_o,
  output logic          pix_sof_o,
  output logic          pix_eol_o,
  output logic          pix_eof_o,
  output logic          busy_o,
  output logic          done_o
);
  localparam int DEPTH = RD_LAT + 1;
  localparam int PW    = $clog2(DEPTH);
  localparam int TW    = 23;
  localparam int EW    = CW + TW;
  localparam logic [9:0] X_LAST  = 10'(H_RES - 1);
  localparam logic [9:0] Y_LAST  = 10'(V_RES - 1);
  localparam logic [3:0] CREDITS = 4'(DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_DUMP, S_DRAIN, S_FIN} state_t;

  state_t        state_q;
  logic [AW-1:0] addr_q, addr_d;
  logic [9:0]    x_q, x_d, y_q, y_d;
  logic          ren_q, busy_q, done_q;
  logic [RD_LAT-1:0] tv_q;
  logic [TW-1:0] tag_q [RD_LAT];
  logic [EW-1:0] fifo_q [DEPTH];
  logic [PW-1:0] wptr_q, rptr_q;
  logic [3:0]    cnt_q, inflight, total_d;

  logic          last_pos, arr_v, fifo_empty, pop, fpop, push, issue_ok;
  logic [TW-1:0] cur_tag;
  logic [EW-1:0] arr_ent, pix_ent;

  assign last_pos = (x_q == X_LAST) && (y_q == Y_LAST);
  assign cur_tag  = {x_q, y_q, (x_q == 10'd0) && (y_q == 10'd0), x_q == X_LAST, last_pos};

  always_comb begin
    x_d    = x_q + 10'd1;
    y_d    = y_q;
    addr_d = addr_q + AW'(1);
    if (x_q == X_LAST) begin
      x_d = 10'd0;
      y_d = y_q + 10'd1;
    end
  end

  // Oldest in-flight read lands this cycle; bypass it straight out when the FIFO is empty.
  assign arr_v       = tv_q[RD_LAT-1];
  assign arr_ent     = {rdata_i, tag_q[RD_LAT-1]};
  assign fifo_empty  = (cnt_q == 4'd0);
  assign pix_valid_o = !fifo_empty || arr_v;
  assign pix_ent     = !fifo_empty ? fifo_q[rptr_q] : (arr_v ? arr_ent : '0);
  assign pop         = pix_valid_o && pix_ready_i;
  assign fpop        = pop && !fifo_empty;
  assign push        = arr_v && !(fifo_empty && pix_ready_i);

  assign pix_data_o = pix_ent[EW-1 -: CW];
  assign pix_x_o    = pix_ent[22:13];
  assign pix_y_o    = pix_ent[12:3];
  assign pix_sof_o  = pix_ent[2];
  assign pix_eol_o  = pix_ent[1];
  assign pix_eof_o  = pix_ent[0];

  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LAT; i++) inflight = inflight + {3'b000, tv_q[i]};
  end

  // Occupancy after this edge; a read is only queued if its data has a guaranteed slot.
  assign total_d  = inflight + cnt_q + {3'b000, ren_q} - {3'b000, pop};
  assign issue_ok = total_d < CREDITS;

  assign addr_o = addr_q;
  assign ren_o  = ren_q;
  assign busy_o = busy_q;
  assign done_o = done_q;

`ifdef FB_DUMP_CLEAR_EN
  logic          wen_q;
  logic [CW-1:0] dout_q;
  assign wen_o  = wen_q;
  assign dout_o = dout_q;
`else
  logic unused_clear;
  assign unused_clear = ^clear_val_i;
  assign wen_o  = 1'b0;
  assign dout_o = '0;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      x_q     <= '0;
      y_q     <= '0;
      ren_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef FB_DUMP_CLEAR_EN
      wen_q   <= 1'b0;
      dout_q  <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            busy_q <= 1'b1;
            addr_q <= '0;
            x_q    <= '0;
            y_q    <= '0;
            if (mode_i) begin
`ifdef FB_DUMP_CLEAR_EN
              state_q <= S_CLEAR;
              wen_q   <= 1'b1;
              dout_q  <= clear_val_i;
`else
              state_q <= S_FIN;
              done_q  <= 1'b1;
`endif
            end else begin
              state_q <= S_DUMP;
              ren_q   <= 1'b1;
            end
          end
        end
`ifdef FB_DUMP_CLEAR_EN
        S_CLEAR: begin
          if (last_pos) begin
            wen_q   <= 1'b0;
            state_q <= S_FIN;
            done_q  <= 1'b1;
          end else begin
            addr_q <= addr_d;
            x_q    <= x_d;
            y_q    <= y_d;
          end
        end
`endif
        S_DUMP: begin
          if (ren_q && last_pos) begin
            ren_q   <= 1'b0;
            state_q <= S_DRAIN;
          end else begin
            if (ren_q) begin
              addr_q <= addr_d;
              x_q    <= x_d;
              y_q    <= y_d;
            end
            ren_q <= issue_ok;
          end
        end
        S_DRAIN: begin
          if (pop && pix_eof_o) begin
            state_q <= S_FIN;
            done_q  <= 1'b1;
          end
        end
        S_FIN: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Tag pipeline mirrors the RAM latency so each rdata word meets its own x/y/flags.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tv_q   <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      for (int i = 0; i < RD_LAT; i++) tag_q[i] <= '0;
      for (int i = 0; i < DEPTH; i++) fifo_q[i] <= '0;
    end else begin
      for (int i = RD_LAT - 1; i > 0; i--) begin
        tv_q[i]  <= tv_q[i-1];
        tag_q[i] <= tag_q[i-1];
      end
      tv_q[0]  <= ren_q;
      tag_q[0] <= cur_tag;
      if (push) begin
        fifo_q[wptr_q] <= arr_ent;
        wptr_q         <= ptr_inc(wptr_q);
      end
      if (fpop) rptr_q <= ptr_inc(rptr_q);
      cnt_q <= cnt_q + {3'b000, push} - {3'b000, fpop};
    end
  end
endmodule

// File: tb/tb_fb_dump.sv
// tb/tb_fb_dump.sv - directed bench for fb_dump (4x3 frame, RD_LAT 1 and 3)
module tb_fb_dump;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, start, mode, pix_ready;
  logic [5:0] clear_val;
  int total = 0;
  int bad   = 0;

  logic [3:0] a_addr, b_addr;
  logic [5:0] a_dout, b_dout, a_rdata, b_rdata, a_data, b_data;
  logic [9:0] a_x, a_y, b_x, b_y;
  logic a_wen, a_ren, a_valid, a_sof, a_eol, a_eof, a_busy, a_done;
  logic b_wen, b_ren, b_valid, b_sof, b_eol, b_eof, b_busy, b_done;

  fb_dump #(.H_RES(4), .V_RES(3), .CW(6), .AW(4), .RD_LAT(1)) u_dut_a (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .mode_i(mode), .clear_val_i(clear_val),
    .addr_o(a_addr), .wen_o(a_wen), .dout_o(a_dout), .ren_o(a_ren), .rdata_i(a_rdata),
    .pix_valid_o(a_valid), .pix_ready_i(pix_ready), .pix_data_o(a_data), .pix_x_o(a_x),
    .pix_y_o(a_y), .pix_sof_o(a_sof), .pix_eol_o(a_eol), .pix_eof_o(a_eof),
    .busy_o(a_busy), .done_o(a_done));

  fb_dump #(.H_RES(4), .V_RES(3), .CW(6), .AW(4), .RD_LAT(3)) u_dut_b (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .mode_i(mode), .clear_val_i(clear_val),
    .addr_o(b_addr), .wen_o(b_wen), .dout_o(b_dout), .ren_o(b_ren), .rdata_i(b_rdata),
    .pix_valid_o(b_valid), .pix_ready_i(pix_ready), .pix_data_o(b_data), .pix_x_o(b_x),
    .pix_y_o(b_y), .pix_sof_o(b_sof), .pix_eol_o(b_eol), .pix_eof_o(b_eof),
    .busy_o(b_busy), .done_o(b_done));

  // Framebuffer models: mem[k] = k, read latency 1 and 3.
  logic [5:0] a_p0, b_p0, b_p1, b_p2;
  always @(posedge clk) begin
    a_p0 <= {2'b00, a_addr};
    b_p0 <= {2'b00, b_addr};
    b_p1 <= b_p0;
    b_p2 <= b_p1;
  end
  assign a_rdata = a_p0;
  assign b_rdata = b_p2;

  logic [28:0] a_cur, b_cur;
  logic [43:0] a_vec, b_vec;
  assign a_cur = {a_data, a_x, a_y, a_sof, a_eol, a_eof};
  assign b_cur = {b_data, b_x, b_y, b_sof, b_eol, b_eof};
  assign a_vec = {a_addr, a_wen, a_dout, a_ren, a_valid, a_cur, a_busy, a_done};
  assign b_vec = {b_addr, b_wen, b_dout, b_ren, b_valid, b_cur, b_busy, b_done};

  function automatic logic [28:0] exp_pix(input int k);
    logic [9:0] ex, ey;
    ex = 10'(k % 4);
    ey = 10'(k / 4);
    return {6'(k), ex, ey, k == 0, (k % 4) == 3, k == 11};
  endfunction

  task automatic settle();
    start = 1'b0;
    pix_ready = 1'b1;
    repeat (30) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; mode = 1'b0; clear_val = '0; pix_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++; if (a_vec !== '0) begin bad++; $display("FAIL reset_a: got %h want 0", a_vec); end
    total++; if (b_vec !== '0) begin bad++; $display("FAIL reset_b: got %h want 0", b_vec); end
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    total++; if (a_vec !== '0) begin bad++; $display("FAIL reset_rel_a: got %h want 0", a_vec); end
  endtask

`ifdef FB_DUMP_CLEAR_EN
  task automatic test_clear();
    int wcnt = 0, dones = 0, done_cyc = -1;
    mode = 1'b1; clear_val = 6'b110000;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0; mode = 1'b0;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      @(negedge clk);
      if (a_wen === 1'b1) begin
        total++;
        if ({a_addr, a_dout} !== {4'(wcnt), 6'b110000} || cyc != wcnt + 1) begin
          bad++; $display("FAIL clear_wr[%0d]: got addr=%0d dout=%b cyc=%0d want addr=%0d dout=110000 cyc=%0d",
                          wcnt, a_addr, a_dout, cyc, wcnt, wcnt + 1);
        end
        wcnt++;
      end
      total++; if (a_ren !== 1'b0) begin bad++; $display("FAIL clear_ren: got %b want 0", a_ren); end
      if (a_done === 1'b1) begin dones++; done_cyc = cyc; end
      @(posedge clk); #1;
    end
    total++; if (wcnt != 12) begin bad++; $display("FAIL clear_count: got %0d want 12", wcnt); end
    total++; if (done_cyc != 13) begin bad++; $display("FAIL clear_done_cyc: got %0d want 13", done_cyc); end
    total++; if (dones != 1) begin bad++; $display("FAIL clear_dones: got %0d want 1", dones); end
  endtask
`else
  task automatic test_clear();
    int dones = 0, done_cyc = -1;
    mode = 1'b1; clear_val = 6'b110000;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0; mode = 1'b0;
    for (int cyc = 1; cyc <= 10; cyc++) begin
      @(negedge clk);
      total++;
      if ({a_wen, a_ren, b_wen, b_ren} !== 4'b0000) begin
        bad++; $display("FAIL noclr_access: got %b want 0000", {a_wen, a_ren, b_wen, b_ren});
      end
      if (a_done === 1'b1) begin dones++; done_cyc = cyc; end
      @(posedge clk); #1;
    end
    total++; if (done_cyc != 1) begin bad++; $display("FAIL noclr_done_cyc: got %0d want 1", done_cyc); end
    total++; if (dones != 1) begin bad++; $display("FAIL noclr_dones: got %0d want 1", dones); end
  endtask
`endif

  task automatic test_dump_lat1();
    int idx = 0, first = -1, last_acc = -1, done_cyc = -1, dones = 0;
    pix_ready = 1'b1; mode = 1'b0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(negedge clk);
      total++; if (a_wen !== 1'b0) begin bad++; $display("FAIL dump1_wen: got %b want 0", a_wen); end
      if (a_valid === 1'b1) begin
        if (first < 0) first = cyc;
        total++;
        if (a_cur !== exp_pix(idx)) begin
          bad++; $display("FAIL dump1_pix[%0d]: got %h want %h", idx, a_cur, exp_pix(idx));
        end
        idx++; last_acc = cyc;
      end
      if (a_done === 1'b1) begin dones++; if (done_cyc < 0) done_cyc = cyc; end
      @(posedge clk); #1;
    end
    total++; if (first != 2) begin bad++; $display("FAIL dump1_first: got %0d want 2", first); end
    total++; if (idx != 12) begin bad++; $display("FAIL dump1_count: got %0d want 12", idx); end
    total++; if (dones != 1) begin bad++; $display("FAIL dump1_dones: got %0d want 1", dones); end
    total++; if (done_cyc != 14) begin bad++; $display("FAIL dump1_done_cyc: got %0d want 14", done_cyc); end
    total++;
    if (done_cyc != last_acc + 1) begin
      bad++; $display("FAIL dump1_done_after_eof: got %0d want %0d", done_cyc, last_acc + 1);
    end
  endtask

  task automatic test_dump_lat3_bp();
    logic [31:0] rpat = 32'hB53C_96E1;
    logic [28:0] held = '0;
    logic stalled = 1'b0;
    int idx = 0, issued = 0, accepted = 0, dones = 0, eof_cyc = -1, done_cyc = -1;
    mode = 1'b0; pix_ready = 1'b0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0; pix_ready = rpat[0];
    for (int cyc = 1; cyc <= 100; cyc++) begin
      @(negedge clk);
      if (stalled) begin
        total++;
        if (b_valid !== 1'b1 || b_cur !== held) begin
          bad++; $display("FAIL lat3_stable: got v=%b %h want v=1 %h", b_valid, b_cur, held);
        end
      end
      if (b_valid === 1'b1 && pix_ready) begin
        total++;
        if (b_cur !== exp_pix(idx)) begin
          bad++; $display("FAIL lat3_pix[%0d]: got %h want %h", idx, b_cur, exp_pix(idx));
        end
        if (b_eof === 1'b1) eof_cyc = cyc;
        idx++; accepted++;
      end
      if (b_ren === 1'b1) issued++;
      total++;
      if (issued - accepted > 4) begin
        bad++; $display("FAIL lat3_credit: got %0d outstanding want <=4", issued - accepted);
      end
      total++; if (b_wen !== 1'b0) begin bad++; $display("FAIL lat3_wen: got %b want 0", b_wen); end
      stalled = b_valid && !pix_ready;
      held = b_cur;
      if (b_done === 1'b1) begin dones++; done_cyc = cyc; end
      @(posedge clk); #1 pix_ready = rpat[cyc % 32];
    end
    pix_ready = 1'b1;
    total++; if (idx != 12) begin bad++; $display("FAIL lat3_count: got %0d want 12", idx); end
    total++; if (dones != 1) begin bad++; $display("FAIL lat3_dones: got %0d want 1", dones); end
    total++;
    if (eof_cyc < 0 || done_cyc != eof_cyc + 1) begin
      bad++; $display("FAIL lat3_done_cyc: got %0d want %0d", done_cyc, eof_cyc + 1);
    end
  endtask

  task automatic test_busy();
    int idx = 0, dones = 0;
    pix_ready = 1'b1; mode = 1'b0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(negedge clk);
      if (cyc == 1) begin
        total++; if (a_busy !== 1'b1) begin bad++; $display("FAIL busy_high: got %b want 1", a_busy); end
      end
      if (a_valid === 1'b1) begin
        total++;
        if (a_cur !== exp_pix(idx)) begin
          bad++; $display("FAIL busy_pix[%0d]: got %h want %h", idx, a_cur, exp_pix(idx));
        end
        idx++;
      end
      if (a_done === 1'b1) dones++;
      @(posedge clk); #1 start = (cyc < 11) && (cyc % 2 == 1);
    end
    total++; if (idx != 12) begin bad++; $display("FAIL busy_count: got %0d want 12", idx); end
    total++; if (dones != 1) begin bad++; $display("FAIL busy_dones: got %0d want 1", dones); end
  endtask

  task automatic test_abort();
    int acc = 0, seen_done = 0, idx = 0, dones = 0;
    pix_ready = 1'b1; mode = 1'b0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int cyc = 1; cyc <= 20 && acc < 5; cyc++) begin
      @(negedge clk);
      if (a_valid === 1'b1) acc++;
      if (a_done === 1'b1) seen_done++;
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    @(negedge clk);
    total++; if (acc != 5) begin bad++; $display("FAIL abort_acc: got %0d want 5", acc); end
    total++; if (a_vec !== '0) begin bad++; $display("FAIL abort_rst_a: got %h want 0", a_vec); end
    total++; if (b_vec !== '0) begin bad++; $display("FAIL abort_rst_b: got %h want 0", b_vec); end
    @(posedge clk); #1 rst_n = 1'b1;
    for (int cyc = 0; cyc < 5; cyc++) begin
      @(negedge clk);
      if (a_done === 1'b1 || b_done === 1'b1) seen_done++;
      total++;
      if ({a_valid, b_valid} !== 2'b00) begin
        bad++; $display("FAIL abort_stale: got %b want 00", {a_valid, b_valid});
      end
      @(posedge clk); #1;
    end
    total++; if (seen_done != 0) begin bad++; $display("FAIL abort_done: got %0d want 0", seen_done); end
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(negedge clk);
      if (a_valid === 1'b1) begin
        total++;
        if (a_cur !== exp_pix(idx)) begin
          bad++; $display("FAIL abort_pix[%0d]: got %h want %h", idx, a_cur, exp_pix(idx));
        end
        idx++;
      end
      if (a_done === 1'b1) dones++;
      @(posedge clk); #1;
    end
    total++; if (idx != 12) begin bad++; $display("FAIL abort_count: got %0d want 12", idx); end
    total++; if (dones != 1) begin bad++; $display("FAIL abort_dones: got %0d want 1", dones); end
  endtask

  initial begin
    test_reset();
    test_clear();
    settle();
    test_dump_lat1();
    settle();
    test_dump_lat3_bp();
    settle();
    test_busy();
    settle();
    test_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
